// File: rtl/efib_sequencer.sv
// efib_sequencer: multi-cycle controller computing the extended Fibonacci term
//   f(0)=1, f(1)=1, f(n)=f(n-1)+n*f(n-2)
// Each loop iteration takes three states: MUL (i*a), ADD (b+prod) and UPD
// (shift the window and test for the last term). Results are truncated to N
// bits. A sticky overflow flag records any truncation during the run.
module efib_sequencer #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] n_in,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] result,
   output logic         overflow
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      INIT = 3'd1,
      MUL  = 3'd2,
      ADD  = 3'd3,
      UPD  = 3'd4,
      FIN  = 3'd5
   } state_t;

   localparam logic [N-1:0] ONE = N'(1);
   localparam logic [N-1:0] TWO = N'(2);

   state_t         state, state_nxt;
   logic [N-1:0]   n_reg;     // term index captured on accept
   logic [N-1:0]   a;         // f(i-2)
   logic [N-1:0]   b;         // f(i-1)
   logic [N-1:0]   i;         // index of the term being built
   logic [N-1:0]   prod;      // low half of i*a
   logic [N-1:0]   sum_reg;   // low N bits of b+prod

   logic [2*N-1:0] mul_full;
   logic [N:0]     add_full;

   // Full-width arithmetic so truncation can be detected
   assign mul_full = {{N{1'b0}}, i} * {{N{1'b0}}, a};
   assign add_full = {1'b0, b} + {1'b0, prod};

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = INIT;
         INIT: state_nxt = (n_reg < TWO) ? FIN : MUL;
         MUL:  state_nxt = ADD;
         ADD:  state_nxt = UPD;
         UPD:  state_nxt = (i == n_reg) ? IDLE : MUL;
         FIN:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath registers and registered handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         n_reg    <= '0;
         a        <= '0;
         b        <= '0;
         i        <= '0;
         prod     <= '0;
         sum_reg  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
         overflow <= 1'b0;
      end else begin
         // done is a single-cycle pulse; only UPD/FIN raise it
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  n_reg    <= n_in;
                  result   <= '0;
                  overflow <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            INIT: begin
               a <= ONE;
               b <= ONE;
               i <= TWO;
            end
            MUL: begin
               if (mul_full[2*N-1:N] != '0) overflow <= 1'b1;
               prod <= mul_full[N-1:0];
            end
            ADD: begin
               if (add_full[N]) overflow <= 1'b1;
               sum_reg <= add_full[N-1:0];
            end
            UPD: begin
               a <= b;
               b <= sum_reg;
               if (i == n_reg) begin
                  // Last term: i stops at n_reg so it never wraps
                  result <= sum_reg;
                  done   <= 1'b1;
                  busy   <= 1'b0;
               end else begin
                  i <= i + ONE;
               end
            end
            FIN: begin
               result <= ONE;
               done   <= 1'b1;
               busy   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_efib_sequencer.sv
// Directed bench for efib_sequencer (N=8); expected values computed by hand.
module tb_efib_sequencer;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] n_in;
   logic       busy;
   logic       done;
   logic [7:0] result;
   logic       overflow;

   int total = 0;
   int bad   = 0;

   efib_sequencer #(.N(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .n_in     (n_in),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge, then settle before sampling/driving
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept a run (edge 0), scramble n_in afterwards, count edges until done.
   // lat = -1 if done never arrives within the budget.
   task automatic launch(input logic [7:0] n, output int lat);
      start = 1'b1;
      n_in  = n;
      tick();
      start = 1'b0;
      n_in  = 8'hA5;
      lat   = -1;
      for (int k = 1; k <= 300; k++) begin
         tick();
         if (done) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; n_in = '0;
      tick(); tick();
      rst = 1'b0;
      total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (done !== 1'b0)     begin bad++; $display("FAIL reset_done got=%b want=0", done); end
      total++; if (result !== 8'd0)   begin bad++; $display("FAIL reset_result got=%0d want=0", result); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", overflow); end
   endtask

   task automatic test_n0();
      start = 1'b1; n_in = 8'd0;
      tick();  // edge 0
      start = 1'b0;
      total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL n0_cyc1 busy=%b done=%b want busy=1 done=0", busy, done); end
      tick();  // edge 1
      total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL n0_cyc2 busy=%b done=%b want busy=1 done=0", busy, done); end
      tick();  // edge 2
      total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL n0_done done=%b busy=%b want done=1 busy=0", done, busy); end
      total++; if (result !== 8'd1)   begin bad++; $display("FAIL n0_result got=%0d want=1", result); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL n0_ovf got=%b want=0", overflow); end
      tick();
      total++; if (done !== 1'b0)     begin bad++; $display("FAIL n0_pulse done=%b want=0", done); end
      total++; if (result !== 8'd1)   begin bad++; $display("FAIL n0_hold got=%0d want=1", result); end
   endtask

   task automatic test_small();
      int lat;
      launch(8'd1, lat);
      total++; if (lat !== 2)         begin bad++; $display("FAIL n1_lat got=%0d want=2", lat); end
      total++; if (result !== 8'd1)   begin bad++; $display("FAIL n1_result got=%0d want=1", result); end
      tick();
      launch(8'd2, lat);
      total++; if (lat !== 4)         begin bad++; $display("FAIL n2_lat got=%0d want=4", lat); end
      total++; if (result !== 8'd3)   begin bad++; $display("FAIL n2_result got=%0d want=3", result); end
      tick();
   endtask

   task automatic test_n6();
      int lat;
      launch(8'd6, lat);
      total++; if (lat !== 16)        begin bad++; $display("FAIL n6_lat got=%0d want=16", lat); end
      total++; if (result !== 8'd156) begin bad++; $display("FAIL n6_result got=%0d want=156", result); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL n6_ovf got=%b want=0", overflow); end
      tick();
   endtask

   task automatic test_overflow();
      int lat;
      launch(8'd7, lat);
      total++; if (lat !== 19)        begin bad++; $display("FAIL n7_lat got=%0d want=19", lat); end
      total++; if (result !== 8'd236) begin bad++; $display("FAIL n7_result got=%0d want=236", result); end
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL n7_ovf got=%b want=1", overflow); end
      tick();
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL n7_ovf_hold got=%b want=1", overflow); end
      launch(8'd3, lat);
      total++; if (lat !== 7)         begin bad++; $display("FAIL n3_lat got=%0d want=7", lat); end
      total++; if (result !== 8'd6)   begin bad++; $display("FAIL n3_result got=%0d want=6", result); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL n3_ovf got=%b want=0", overflow); end
      tick();
   endtask

   task automatic test_back_to_back();
      int ndone;
      int edges[3];
      ndone = 0;
      start = 1'b1; n_in = 8'd4;
      tick();  // edge 0: first accept
      for (int k = 1; k <= 32; k++) begin
         tick();
         if (done) begin
            total++; if (result !== 8'd18) begin bad++; $display("FAIL b2b_result edge=%0d got=%0d want=18", k, result); end
            if (ndone < 3) edges[ndone] = k;
            ndone++;
         end
         // Disturb inputs while busy; restore before the next accept edge
         if (k == 3) n_in  = 8'd9;
         if (k == 5) start = 1'b0;
         if (k == 6) start = 1'b1;
         if (k == 8) n_in  = 8'd4;
      end
      start = 1'b0;
      total++; if (ndone !== 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", ndone); end
      if (ndone >= 3) begin
         total++;
         if (edges[0] !== 10 || edges[1] !== 21 || edges[2] !== 32) begin
            bad++; $display("FAIL b2b_edges got=%0d,%0d,%0d want=10,21,32", edges[0], edges[1], edges[2]);
         end
      end
      tick(); tick();
      total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL b2b_idle busy=%b done=%b want 0,0", busy, done); end
   endtask

   task automatic test_reset_mid();
      int lat;
      int seen;
      start = 1'b1; n_in = 8'd6;
      tick();  // edge 0
      start = 1'b0;
      for (int k = 1; k <= 7; k++) tick();
      rst = 1'b1;
      tick();  // edge 8
      rst = 1'b0;
      total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
      total++; if (result !== 8'd0)   begin bad++; $display("FAIL rmid_result got=%0d want=0", result); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rmid_ovf got=%b want=0", overflow); end
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         if (done || busy) seen++;
         tick();
      end
      total++; if (seen !== 0)        begin bad++; $display("FAIL rmid_quiet activity=%0d want=0", seen); end
      launch(8'd5, lat);
      total++; if (lat !== 13)        begin bad++; $display("FAIL rmid_n5_lat got=%0d want=13", lat); end
      total++; if (result !== 8'd48)  begin bad++; $display("FAIL rmid_n5_result got=%0d want=48", result); end
      tick();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; n_in = '0;
      test_reset();
      test_n0();
      test_small();
      test_n6();
      test_overflow();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
